// File: rtl/shifter_arbiter.sv
// Round-robin arbiter that time-shares one 32-bit barrel shifter among N_REQ
// requesters; results are registered and returned with the owner's ID.

module barrelshifter32 (
  input  logic [31:0] a,
  input  logic [4:0]  b,
  input  logic [1:0]  aluc,
  output logic [31:0] c
);
  logic [31:0] stage_val;
  logic        fill_bit;

  // Log-depth shifter: stage i shifts by 2**i when b[i] is set.
  always_comb begin
    stage_val = a;
    fill_bit  = (aluc == 2'b00) & a[31];
    for (int i = 0; i < 5; i++) begin
      if (b[i]) begin
        if (aluc[0]) begin
          stage_val = stage_val << (1 << i);
        end else begin
          stage_val = (stage_val >> (1 << i)) | ({32{fill_bit}} << (32 - (1 << i)));
        end
      end
    end
    c = stage_val;
  end
endmodule

module shifter_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [5*N_REQ-1:0]   req_b,
  input  logic [2*N_REQ-1:0]   req_aluc,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_data,
  output logic [ID_W-1:0]      res_id,
  output logic [15:0]          op_count
);
  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic [31:0]       res_data_reg;
  logic [ID_W-1:0]   res_id_reg;
  logic [15:0]       op_count_reg;

  logic [31:0]       a_arr    [N_REQ];
  logic [4:0]        b_arr    [N_REQ];
  logic [1:0]        aluc_arr [N_REQ];

  logic              grant_en;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic              xfer;
  logic [31:0]       shift_out;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign a_arr[gi]    = req_a[32*gi +: 32];
      assign b_arr[gi]    = req_b[5*gi +: 5];
      assign aluc_arr[gi] = req_aluc[2*gi +: 2];
    end
  endgenerate

  // A held result that is not being retired blocks any new grant.
  assign grant_en = !rst && ((state_reg == IDLE) || res_ready);

  always_comb begin
    logic [ID_W-1:0] scan_idx;
    scan_idx    = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = ID_W'((int'(ptr_reg) + k) % N_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_en && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign xfer     = grant_en && grant_found;
  assign ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  barrelshifter32 u_shifter (
    .a    (a_arr[grant_idx]),
    .b    (b_arr[grant_idx]),
    .aluc (aluc_arr[grant_idx]),
    .c    (shift_out)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (xfer) state_next = HOLD;
      HOLD: begin
        if (xfer)           state_next = HOLD;
        else if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      res_data_reg <= '0;
      res_id_reg   <= '0;
      op_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (xfer) begin
        res_data_reg <= shift_out;
        res_id_reg   <= grant_idx;
        ptr_reg      <= ptr_next;
        op_count_reg <= op_count_reg + 16'd1;
      end
    end
  end

  assign res_valid = (state_reg == HOLD);
  assign res_data  = res_data_reg;
  assign res_id    = res_id_reg;
  assign op_count  = op_count_reg;
endmodule
